timer_core: RTL and testbench

//   Function half of the machine timer. Counts the 64-bit mtime. Compares it

---
 rtl/timer_core.sv | 76 +++++++
 tb/tb_timer_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/timer_core.sv
// Machine timer core: prescaled 64-bit mtime counter, unsigned compare against
// mtimecmp driving mtip, and the registered software interrupt bit.
module timer_core #(
   parameter int unsigned PRESC_W   = 16,
   parameter int unsigned PRESC_DIV = 10,
   parameter logic [63:0] MTIME_RST = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [63:0] mtimecmp,
   input  logic [31:0] msip,
   output logic [63:0] mtime,
   output logic        tick,
   output logic        mtip,
   output logic        msip_irq
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC_DIV - 32'd1);

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [63:0]        mtime_q, mtime_d;
   logic               tick_q, tick_d;
   logic               mtip_q, mtip_d;
   logic               msip_irq_q, msip_irq_d;
   logic               msip_hi_unused;

   // Only bit 0 of the software interrupt register is architected.
   assign msip_hi_unused = ^msip[31:1];

   // Next-state: prescaler/mtime advance, compare and msip sampling.
   always_comb begin
      presc_d    = presc_q;
      mtime_d    = mtime_q;
      tick_d     = 1'b0;
      if (en) begin
         if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            mtime_d = mtime_q + 64'd1;
            tick_d  = 1'b1;
         end else begin
            presc_d = presc_q + PRESC_W'(1);
            tick_d  = 1'b0;
         end
      end else begin
         presc_d = presc_q;
         mtime_d = mtime_q;
      end
      // Compares the currently visible mtime, so mtip trails mtime by one edge.
      mtip_d     = (mtime_q >= mtimecmp);
      msip_irq_d = msip[0];
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q    <= '0;
         mtime_q    <= MTIME_RST;
         tick_q     <= 1'b0;
         mtip_q     <= 1'b0;
         msip_irq_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         mtime_q    <= mtime_d;
         tick_q     <= tick_d;
         mtip_q     <= mtip_d;
         msip_irq_q <= msip_irq_d;
      end
   end

   assign mtime    = mtime_q;
   assign tick     = tick_q;
   assign mtip     = mtip_q;
   assign msip_irq = msip_irq_q;

endmodule

// File: tb/tb_timer_core.sv
// Bench for timer_core: three configurations (div 4, div 1, div 1 near wrap)
// checked against an enabled-edge-count arithmetic model.
module tb_timer_core;

   localparam int N = 3;
   localparam logic [63:0] WRAP_RST = 64'hFFFF_FFFF_FFFF_FFFE;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] msip;
   logic [63:0] cmp     [N];
   logic [63:0] mtime_o [N];
   logic        tick_o  [N];
   logic        mtip_o  [N];
   logic        msip_o  [N];

   longint unsigned div     [N] = '{64'd4, 64'd1, 64'd1};
   logic [63:0]     rst_val [N] = '{64'd0, 64'd0, WRAP_RST};

   longint unsigned en_cnt   [N];
   logic            exp_tick [N];
   logic            exp_mtip [N];
   logic            exp_msip [N];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   timer_core #(.PRESC_W(16), .PRESC_DIV(4), .MTIME_RST(64'd0)) u_div4 (
      .clk(clk), .rst(rst), .en(en), .mtimecmp(cmp[0]), .msip(msip),
      .mtime(mtime_o[0]), .tick(tick_o[0]), .mtip(mtip_o[0]), .msip_irq(msip_o[0]));

   timer_core #(.PRESC_W(16), .PRESC_DIV(1), .MTIME_RST(64'd0)) u_div1 (
      .clk(clk), .rst(rst), .en(en), .mtimecmp(cmp[1]), .msip(msip),
      .mtime(mtime_o[1]), .tick(tick_o[1]), .mtip(mtip_o[1]), .msip_irq(msip_o[1]));

   timer_core #(.PRESC_W(16), .PRESC_DIV(1), .MTIME_RST(WRAP_RST)) u_wrap (
      .clk(clk), .rst(rst), .en(en), .mtimecmp(cmp[2]), .msip(msip),
      .mtime(mtime_o[2]), .tick(tick_o[2]), .mtip(mtip_o[2]), .msip_irq(msip_o[2]));

   // mtime is the reset value plus one per full prescaler period of enabled edges.
   function automatic logic [63:0] model_mtime(int i);
      return rst_val[i] + 64'(en_cnt[i] / div[i]);
   endfunction

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic reset_model();
      for (int i = 0; i < N; i++) begin
         en_cnt[i]   = 64'd0;
         exp_tick[i] = 1'b0;
         exp_mtip[i] = 1'b0;
         exp_msip[i] = 1'b0;
      end
   endtask

   task automatic check_all(string phase);
      for (int i = 0; i < N; i++) begin
         check($sformatf("%s[%0d].mtime", phase, i), mtime_o[i], model_mtime(i));
         check($sformatf("%s[%0d].tick", phase, i), 64'(tick_o[i]), 64'(exp_tick[i]));
         check($sformatf("%s[%0d].mtip", phase, i), 64'(mtip_o[i]), 64'(exp_mtip[i]));
         check($sformatf("%s[%0d].msip", phase, i), 64'(msip_o[i]), 64'(exp_msip[i]));
      end
   endtask

   // One clock edge: advance the model from the inputs seen at the edge, then check.
   task automatic step(string phase);
      logic [63:0] m_old;
      @(posedge clk);
      if (rst) begin
         reset_model();
      end else begin
         for (int i = 0; i < N; i++) begin
            m_old       = model_mtime(i);
            exp_mtip[i] = (m_old >= cmp[i]);
            exp_msip[i] = msip[0];
            if (en) begin
               en_cnt[i]++;
               exp_tick[i] = ((en_cnt[i] % div[i]) == 64'd0);
            end else begin
               exp_tick[i] = 1'b0;
            end
         end
      end
      #1;
      check_all(phase);
   endtask

   initial begin
      rst    = 1'b1;
      en     = 1'b0;
      msip   = 32'd0;
      cmp[0] = 64'd3;
      cmp[1] = 64'd5;
      cmp[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      reset_model();
      step("rst");
      step("rst");
      rst = 1'b0;
      en  = 1'b1;

      // Wrap instance: FE -> FF -> 0, mtip follows one edge behind.
      step("run");
      check("wrap.mtime_ff", mtime_o[2], 64'hFFFF_FFFF_FFFF_FFFF);
      step("run");
      check("wrap.mtime_0", mtime_o[2], 64'd0);
      check("wrap.mtip_hi", 64'(mtip_o[2]), 64'd1);
      step("run");
      check("wrap.mtip_lo", 64'(mtip_o[2]), 64'd0);
      step("run");
      check("div4.mtime_1", mtime_o[0], 64'd1);
      check("div4.tick_1", 64'(tick_o[0]), 64'd1);
      step("run");
      check("div1.mtime_5", mtime_o[1], 64'd5);
      step("run");
      check("div1.mtip_5", 64'(mtip_o[1]), 64'd1);

      // div4 prescaler sits at 2 here; freeze for three cycles.
      en = 1'b0;
      repeat (3) step("hold");
      check("div4.hold", mtime_o[0], 64'd1);
      en = 1'b1;
      step("resume");
      check("div4.no_inc", mtime_o[0], 64'd1);
      step("resume");
      check("div4.mtime_2", mtime_o[0], 64'd2);
      check("div4.tick_2", 64'(tick_o[0]), 64'd1);

      cmp[1] = 64'd100;
      step("cmp_up");
      check("div1.mtip_clr", 64'(mtip_o[1]), 64'd0);

      msip = 32'hFFFF_FFFE;
      step("msip");
      check("msip.hi_bits", 64'(msip_o[0]), 64'd0);
      msip = 32'h1;
      step("msip");
      check("msip.bit0", 64'(msip_o[0]), 64'd1);

      // Fresh reset, count to mtime=7/presc=3 on div4, then reset mid-cycle.
      rst = 1'b1;
      step("rst2");
      rst = 1'b0;
      repeat (31) step("count");
      check("div4.mtime_7", mtime_o[0], 64'd7);
      #2;
      rst = 1'b1;
      #1;
      reset_model();
      check_all("arst");
      step("arst_hold");
      rst = 1'b0;
      step("restart");
      check("div4.restart", mtime_o[0], 64'd0);

      // Random phase: bursty enable, random msip, mtimecmp moved around mtime.
      for (int c = 0; c < 400; c++) begin
         en   = ($urandom_range(0, 3) != 0);
         msip = $urandom;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0)
               cmp[i] = model_mtime(i) + 64'($urandom_range(0, 6)) - 64'd3;
         end
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
